// File: rtl/hazard_sched_pkg.sv
// Shared definitions for the pipeline hazard scheduler: FSM state encoding,
// the IF/ID nop pattern and internal counter widths.
package hazard_sched_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INS = {6'b111111, 26'b0};

    // Memory wait counter covers MEM_TIMEOUT up to 255; bubble counter covers up to 7.
    localparam int WAIT_W  = 8;
    localparam int LDCNT_W = 3;

endpackage

// File: rtl/hazard_sched_detect.sv
// Combinational load-use compare between the ID source operands and the load in EX.
// Kept standalone so the same compare can feed forwarding checks.
module hazard_detect
    import hazard_sched_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       ex_memtoreg,
    input  logic       ex_regwr,
    input  logic [4:0] ex_rt,
    output logic       luh
);

    logic [4:0] src [2];
    logic [1:0] use_src;
    logic [1:0] hit;

    assign src[0]     = id_rs;
    assign src[1]     = id_rt;
    assign use_src[0] = id_use_rs;
    assign use_src[1] = id_use_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign hit[gi] = use_src[gi] && (src[gi] == ex_rt);
        end
    endgenerate

    // $zero never carries a real dependency, so a load targeting it cannot stall.
    assign luh = ex_memtoreg && ex_regwr && (ex_rt != 5'd0) && (|hit);

endmodule

// File: rtl/hazard_sched.sv
// Per-cycle hazard scheduler for the 5-stage pipeline: load-use bubbles, branch/jump
// redirects and data-memory wait states, with a sticky timeout flag and a stall counter.
module hazard_sched
    import hazard_sched_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 255,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_memtoreg,
    input  logic             ex_regwr,
    input  logic [4:0]       ex_rt,
    input  logic             B_J_jump,
    input  logic             Jr_jump,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             loadad,
    output logic             pc_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             freeze_back,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [LDCNT_W-1:0] LD_INIT    = LDCNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [LDCNT_W-1:0] LD_ONE     = LDCNT_W'(1);
    localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    state_t             state_reg, state_next;
    logic [LDCNT_W-1:0] cnt_reg, cnt_next;
    logic [WAIT_W-1:0]  wait_reg;
    logic               mem_err_reg;
    logic [CNT_W-1:0]   stall_cnt_reg;

    logic luh;
    logic redir;
    logic memstall;
    logic waiting;

    hazard_detect u_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .ex_memtoreg (ex_memtoreg),
        .ex_regwr    (ex_regwr),
        .ex_rt       (ex_rt),
        .luh         (luh)
    );

    assign redir    = B_J_jump | Jr_jump;
    assign memstall = mem_req & ~mem_ready;

    always_comb begin
        // A MEMWAIT cycle that sees mem_ready falls through and decodes like RUN.
        state_next  = (state_reg == ST_MEMWAIT) ? ST_RUN : state_reg;
        cnt_next    = cnt_reg;
        waiting     = 1'b0;
        loadad      = 1'b0;
        pc_hold     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        freeze_back = 1'b0;
        if (!rst) begin
            if (memstall || (state_reg == ST_MEMWAIT && !mem_ready)) begin
                waiting     = 1'b1;
                loadad      = 1'b1;
                pc_hold     = 1'b1;
                freeze_back = 1'b1;
                state_next  = ST_MEMWAIT;
            end else if (redir) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                state_next  = ST_RUN;
            end else if (state_reg == ST_LDSTALL) begin
                loadad      = 1'b1;
                pc_hold     = 1'b1;
                idex_bubble = 1'b1;
                if (cnt_reg <= LD_ONE) begin
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt_reg - LD_ONE;
                end
            end else if (luh) begin
                loadad      = 1'b1;
                pc_hold     = 1'b1;
                idex_bubble = 1'b1;
                if (LOAD_STALL_CYCLES > 1) begin
                    state_next = ST_LDSTALL;
                    cnt_next   = LD_INIT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            cnt_reg       <= '0;
            wait_reg      <= '0;
            mem_err_reg   <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (waiting) begin
                if (wait_reg != WAIT_LIMIT) begin
                    wait_reg <= wait_reg + WAIT_W'(1);
                end
                if (wait_reg == WAIT_LIMIT - WAIT_W'(1)) begin
                    mem_err_reg <= 1'b1;
                end
            end else begin
                wait_reg <= '0;
            end
            if (loadad && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign mem_err   = mem_err_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: three instances with different stall/timeout settings share
// one stimulus stream; directed scenarios plus a randomized run against a bubble-count model.
module tb_hazard_sched;

    localparam int N = 3;
    localparam int LS [N] = '{1, 3, 2};
    localparam int TO [N] = '{255, 255, 4};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_use_rs, id_use_rt, ex_memtoreg, ex_regwr;
    logic       B_J_jump, Jr_jump, mem_req, mem_ready;

    // {loadad, pc_hold, ifid_flush, idex_bubble, freeze_back, mem_err}
    logic [5:0]  ctl  [N];
    logic [15:0] scnt [N];

    int m_left    [N];
    int m_wait    [N];
    bit m_waiting [N];
    bit m_err     [N];
    int m_stalls  [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            logic        loadad, pc_hold, ifid_flush, idex_bubble, freeze_back, mem_err;
            logic [15:0] stall_cnt;
            hazard_sched #(
                .LOAD_STALL_CYCLES (LS[gi]),
                .MEM_TIMEOUT       (TO[gi]),
                .CNT_W             (16)
            ) u_dut (
                .clk         (clk),
                .rst         (rst),
                .id_rs       (id_rs),
                .id_rt       (id_rt),
                .id_use_rs   (id_use_rs),
                .id_use_rt   (id_use_rt),
                .ex_memtoreg (ex_memtoreg),
                .ex_regwr    (ex_regwr),
                .ex_rt       (ex_rt),
                .B_J_jump    (B_J_jump),
                .Jr_jump     (Jr_jump),
                .mem_req     (mem_req),
                .mem_ready   (mem_ready),
                .loadad      (loadad),
                .pc_hold     (pc_hold),
                .ifid_flush  (ifid_flush),
                .idex_bubble (idex_bubble),
                .freeze_back (freeze_back),
                .mem_err     (mem_err),
                .stall_cnt   (stall_cnt)
            );
            assign ctl[gi]  = {loadad, pc_hold, ifid_flush, idex_bubble, freeze_back, mem_err};
            assign scnt[gi] = stall_cnt;
        end
    endgenerate

    function automatic bit f_luh();
        return ex_memtoreg && ex_regwr && (ex_rt != 5'd0) &&
               ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
    endfunction

    function automatic bit f_frozen(int k);
        return (mem_req && !mem_ready) || (m_waiting[k] && !mem_ready);
    endfunction

    function automatic logic [5:0] model_ctl(int k);
        logic [5:0] v;
        v    = 6'b0;
        v[0] = m_err[k];
        if (!rst) begin
            if (f_frozen(k)) begin
                v[5] = 1'b1; v[4] = 1'b1; v[1] = 1'b1;
            end else if (B_J_jump || Jr_jump) begin
                v[3] = 1'b1; v[2] = 1'b1;
            end else if (m_left[k] > 0 || f_luh()) begin
                v[5] = 1'b1; v[4] = 1'b1; v[2] = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic model_advance();
        logic [5:0] v;
        for (int k = 0; k < N; k++) begin
            v = model_ctl(k);
            if (rst) begin
                m_left[k] = 0; m_wait[k] = 0; m_waiting[k] = 0; m_err[k] = 0; m_stalls[k] = 0;
            end else begin
                if (v[5] && m_stalls[k] < 65535) m_stalls[k]++;
                if (f_frozen(k)) begin
                    m_waiting[k] = 1;
                    m_wait[k]++;
                    if (m_wait[k] >= TO[k]) m_err[k] = 1;
                    m_left[k] = 0;
                end else begin
                    m_waiting[k] = 0;
                    m_wait[k]    = 0;
                    if (B_J_jump || Jr_jump) m_left[k] = 0;
                    else if (m_left[k] > 0)  m_left[k]--;
                    else if (f_luh())        m_left[k] = LS[k] - 1;
                end
            end
        end
    endtask

    task automatic clear_in();
        id_rs = 0; id_rt = 0; ex_rt = 0;
        id_use_rs = 0; id_use_rt = 0; ex_memtoreg = 0; ex_regwr = 0;
        B_J_jump = 0; Jr_jump = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic set_luh(input logic [4:0] r);
        ex_memtoreg = 1; ex_regwr = 1; ex_rt = r; id_rs = r; id_use_rs = 1;
    endtask

    task automatic next_cycle();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_in();
        next_cycle();
        next_cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        for (int k = 0; k < N; k++) begin
            checks++;
            if (ctl[k] !== 6'b0) begin errors++; $display("FAIL reset_ctl[%0d]: got %b expected %b", k, ctl[k], 6'b0); end
            checks++;
            if (scnt[k] !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt[%0d]: got %0d expected 0", k, scnt[k]); end
        end
        rst = 1; set_luh(5'd8); B_J_jump = 1;
        settle();
        checks++;
        if (ctl[0] !== 6'b0) begin errors++; $display("FAIL rst_no_flush: got %b expected %b", ctl[0], 6'b0); end
        next_cycle();
        rst = 0; clear_in();
        settle();
        checks++;
        if (ctl[1] !== 6'b0) begin errors++; $display("FAIL rst_to_run: got %b expected %b", ctl[1], 6'b0); end
        $display("test_reset: done");
    endtask

    task automatic test_load_use();
        do_reset();
        set_luh(5'd8);
        settle();
        checks++;
        if (ctl[0] !== 6'b110100) begin errors++; $display("FAIL load_use_stall: got %b expected %b", ctl[0], 6'b110100); end
        next_cycle();
        clear_in();
        settle();
        checks++;
        if (ctl[0] !== 6'b0) begin errors++; $display("FAIL load_use_release: got %b expected %b", ctl[0], 6'b0); end
        checks++;
        if (scnt[0] !== 16'd1) begin errors++; $display("FAIL load_use_stall_cnt: got %0d expected 1", scnt[0]); end
        $display("test_load_use: done");
    endtask

    task automatic test_no_stall();
        do_reset();
        ex_memtoreg = 1; ex_regwr = 1; ex_rt = 0; id_rs = 0; id_use_rs = 1;
        settle();
        checks++;
        if (ctl[0] !== 6'b0) begin errors++; $display("FAIL no_stall_r0: got %b expected %b", ctl[0], 6'b0); end
        ex_rt = 8; id_rs = 8; id_use_rs = 0;
        settle();
        checks++;
        if (ctl[0] !== 6'b0) begin errors++; $display("FAIL no_stall_unused: got %b expected %b", ctl[0], 6'b0); end
        id_rt = 8; id_use_rt = 1;
        settle();
        checks++;
        if (ctl[0] !== 6'b110100) begin errors++; $display("FAIL stall_rt_path: got %b expected %b", ctl[0], 6'b110100); end
        next_cycle();
        clear_in();
        ex_memtoreg = 1; ex_regwr = 0; ex_rt = 9; id_rs = 9; id_use_rs = 1;
        settle();
        checks++;
        if (ctl[0] !== 6'b0) begin errors++; $display("FAIL no_stall_noregwr: got %b expected %b", ctl[0], 6'b0); end
        next_cycle();
        clear_in();
        $display("test_no_stall: done");
    endtask

    task automatic test_redir_luh();
        do_reset();
        set_luh(5'd8); B_J_jump = 1;
        settle();
        checks++;
        if (ctl[0] !== 6'b001100) begin errors++; $display("FAIL redir_over_luh: got %b expected %b", ctl[0], 6'b001100); end
        checks++;
        if (ctl[1] !== 6'b001100) begin errors++; $display("FAIL redir_over_luh_l3: got %b expected %b", ctl[1], 6'b001100); end
        next_cycle();
        clear_in();
        settle();
        checks++;
        if (ctl[1] !== 6'b0) begin errors++; $display("FAIL redir_then_run: got %b expected %b", ctl[1], 6'b0); end
        $display("test_redir_luh: done");
    endtask

    task automatic test_multi_stall();
        do_reset();
        set_luh(5'd8);
        settle();
        checks++;
        if (ctl[1] !== 6'b110100) begin errors++; $display("FAIL multi_stall_c1: got %b expected %b", ctl[1], 6'b110100); end
        next_cycle();
        clear_in();
        for (int i = 2; i <= 3; i++) begin
            settle();
            checks++;
            if (ctl[1] !== 6'b110100) begin errors++; $display("FAIL multi_stall_c%0d: got %b expected %b", i, ctl[1], 6'b110100); end
            next_cycle();
        end
        settle();
        checks++;
        if (ctl[1] !== 6'b0) begin errors++; $display("FAIL multi_stall_end: got %b expected %b", ctl[1], 6'b0); end
        checks++;
        if (scnt[1] !== 16'd3) begin errors++; $display("FAIL multi_stall_cnt: got %0d expected 3", scnt[1]); end
        do_reset();
        set_luh(5'd8);
        settle();
        next_cycle();
        clear_in();
        Jr_jump = 1;
        settle();
        checks++;
        if (ctl[1] !== 6'b001100) begin errors++; $display("FAIL jr_in_ldstall: got %b expected %b", ctl[1], 6'b001100); end
        next_cycle();
        Jr_jump = 0;
        settle();
        checks++;
        if (ctl[1] !== 6'b0) begin errors++; $display("FAIL jr_ends_stall: got %b expected %b", ctl[1], 6'b0); end
        $display("test_multi_stall: done");
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            settle();
            checks++;
            if (ctl[0] !== 6'b110010) begin errors++; $display("FAIL mem_wait_c%0d: got %b expected %b", i, ctl[0], 6'b110010); end
            next_cycle();
        end
        mem_ready = 1;
        settle();
        checks++;
        if (ctl[0] !== 6'b0) begin errors++; $display("FAIL mem_ready_release: got %b expected %b", ctl[0], 6'b0); end
        checks++;
        if (ctl[2] !== 6'b000001) begin errors++; $display("FAIL mem_err_t4_after4: got %b expected %b", ctl[2], 6'b000001); end
        next_cycle();
        clear_in();
        settle();
        checks++;
        if (scnt[0] !== 16'd4) begin errors++; $display("FAIL mem_wait_stall_cnt: got %0d expected 4", scnt[0]); end
        $display("test_mem_wait: done");
    endtask

    task automatic test_mem_timeout();
        logic [5:0] exp;
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int k = 1; k <= 10; k++) begin
            settle();
            exp = {5'b11001, (k >= 5) ? 1'b1 : 1'b0};
            checks++;
            if (ctl[2] !== exp) begin errors++; $display("FAIL timeout_c%0d: got %b expected %b", k, ctl[2], exp); end
            next_cycle();
        end
        settle();
        checks++;
        if (scnt[2] !== 16'd10) begin errors++; $display("FAIL timeout_stall_cnt: got %0d expected 10", scnt[2]); end
        rst = 1;
        next_cycle();
        rst = 0; clear_in();
        settle();
        checks++;
        if (ctl[2] !== 6'b0) begin errors++; $display("FAIL timeout_rst_clear: got %b expected %b", ctl[2], 6'b0); end
        checks++;
        if (scnt[2] !== 16'd0) begin errors++; $display("FAIL timeout_rst_cnt: got %0d expected 0", scnt[2]); end
        $display("test_mem_timeout: done");
    endtask

    task automatic test_random();
        logic [5:0] exp;
        int bad;
        bad = errors;
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 59) == 0);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ex_rt       = 5'($urandom_range(0, 3));
            id_use_rs   = 1'($urandom_range(0, 1));
            id_use_rt   = 1'($urandom_range(0, 1));
            ex_memtoreg = ($urandom_range(0, 2) != 0);
            ex_regwr    = ($urandom_range(0, 3) != 0);
            B_J_jump    = ($urandom_range(0, 9) == 0);
            Jr_jump     = ($urandom_range(0, 14) == 0);
            mem_req     = ($urandom_range(0, 4) == 0);
            mem_ready   = ($urandom_range(0, 2) != 0);
            settle();
            for (int k = 0; k < N; k++) begin
                exp = model_ctl(k);
                checks++;
                if (ctl[k] !== exp) begin errors++; $display("FAIL random_ctl[%0d] cyc %0d: got %b expected %b", k, i, ctl[k], exp); end
                checks++;
                if (scnt[k] !== 16'(m_stalls[k])) begin errors++; $display("FAIL random_cnt[%0d] cyc %0d: got %0d expected %0d", k, i, scnt[k], m_stalls[k]); end
            end
            next_cycle();
        end
        rst = 0;
        clear_in();
        $display("test_random: done, %0d new errors", errors - bad);
    endtask

    initial begin
        clear_in();
        test_reset();
        test_load_use();
        test_no_stall();
        test_redir_luh();
        test_multi_stall();
        test_mem_wait();
        test_mem_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
